rand_sched: RTL and testbench

- Sequencer and arbiter for the shared 16-bit LFSR random generator (ports srand / init_srand / randi).
- Seeds the generator from a free-running entropy counter when the player presses start, then lets it mix for a few cycles.
- Afterwards it shares the generator's output among NREQ requesters (note-lane spawner, colour picker, timing jitter, etc.) using round-robin arbitration.
- Detects the all-zero LFSR lock-up state and re-seeds automatically.

---
 rtl/rand_pkg.sv | 24 ++
 rtl/rr_arbiter.sv | 34 +++
 rtl/rand_sched.sv | 172 +++++++++++++++++
 tb/tb_rand_sched.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/rand_pkg.sv
// Types and constants for the random generator scheduler.
package rand_pkg;

   localparam int RAND_W = 16;
   localparam logic [RAND_W-1:0] FALLBACK_SEED = 16'hACE1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SEED = 2'd1,
      WARM = 2'd2,
      RUN  = 2'd3
   } state_t;

   // A zero seed would freeze the LFSR, so the fallback replaces it.
   function automatic logic [RAND_W-1:0] pick_seed(input logic [RAND_W-1:0] ent,
                                                    input logic [RAND_W-1:0] fallback);
      if (ent == 16'h0000) begin
         return fallback;
      end else begin
         return ent;
      end
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: search starts at ptr and ascends with wrap.
module rr_arbiter #(
   parameter int N  = 4,
   parameter int PW = $clog2(N)
) (
   input  logic [N-1:0]  req,
   input  logic [N-1:0]  mask,
   input  logic [PW-1:0] ptr,
   output logic [N-1:0]  grant,
   output logic [PW-1:0] idx
);

   logic          found_s;
   logic [PW-1:0] pos_s;

   // First unmasked request at or after the pointer wins.
   always_comb begin
      grant   = '0;
      idx     = '0;
      found_s = 1'b0;
      pos_s   = '0;
      for (int k = 0; k < N; k++) begin
         pos_s = PW'((int'(ptr) + k) % N);
         if (!found_s && req[pos_s] && !mask[pos_s]) begin
            grant[pos_s] = 1'b1;
            idx          = pos_s;
            found_s      = 1'b1;
         end else begin
            found_s = found_s;
         end
      end
   end

endmodule

// File: rtl/rand_sched.sv
// Seeds the shared LFSR, lets it warm up, then shares its output among
// NREQ requesters round-robin; re-seeds on start or on all-zero lock-up.
module rand_sched
   import rand_pkg::*;
#(
   parameter int NREQ     = 4,
   parameter int SEED_CYC = 2,
   parameter int WARM_CYC = 8,
   parameter logic [RAND_W-1:0] FALLBACK_SEED = rand_pkg::FALLBACK_SEED
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [RAND_W-1:0] randi,
   output logic [RAND_W-1:0] srand,
   output logic              init_srand,
   input  logic [NREQ-1:0]   req,
   output logic [NREQ-1:0]   gnt,
   output logic [RAND_W-1:0] rdata,
   output logic              rvalid,
   output logic              ready
);

   localparam int PW = $clog2(NREQ);
   localparam logic [15:0] SEED_LAST = 16'(SEED_CYC - 1);
   localparam logic [15:0] WARM_LAST = 16'(WARM_CYC - 1);

   state_t            state_r, state_nxt_s;
   logic [15:0]       ent_cnt_r;
   logic [15:0]       phase_r, phase_nxt_s;
   logic [PW-1:0]     ptr_r, ptr_nxt_s;
   logic [RAND_W-1:0] srand_r, srand_nxt_s;
   logic              init_srand_r, init_srand_nxt_s;
   logic [NREQ-1:0]   gnt_r, gnt_nxt_s;
   logic [RAND_W-1:0] rdata_r, rdata_nxt_s;
   logic              rvalid_r, rvalid_nxt_s;
   logic              ready_r, ready_nxt_s;
   logic [NREQ-1:0]   arb_grant_s;
   logic [PW-1:0]     arb_idx_s;

   // The requester being granted this cycle is masked so it cannot win twice.
   rr_arbiter #(.N(NREQ), .PW(PW)) u_arb (
      .req   (req),
      .mask  (gnt_r),
      .ptr   (ptr_r),
      .grant (arb_grant_s),
      .idx   (arb_idx_s)
   );

   // Free-running entropy source for seed capture.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ent_cnt_r <= 16'h0000;
      end else begin
         ent_cnt_r <= ent_cnt_r + 16'h0001;
      end
   end

   // State, counters and registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r      <= IDLE;
         phase_r      <= 16'h0000;
         ptr_r        <= '0;
         srand_r      <= 16'h0000;
         init_srand_r <= 1'b1;
         gnt_r        <= '0;
         rdata_r      <= 16'h0000;
         rvalid_r     <= 1'b0;
         ready_r      <= 1'b0;
      end else begin
         state_r      <= state_nxt_s;
         phase_r      <= phase_nxt_s;
         ptr_r        <= ptr_nxt_s;
         srand_r      <= srand_nxt_s;
         init_srand_r <= init_srand_nxt_s;
         gnt_r        <= gnt_nxt_s;
         rdata_r      <= rdata_nxt_s;
         rvalid_r     <= rvalid_nxt_s;
         ready_r      <= ready_nxt_s;
      end
   end

   // Next-state and next-output decode.
   always_comb begin
      state_nxt_s      = state_r;
      phase_nxt_s      = phase_r;
      ptr_nxt_s        = ptr_r;
      srand_nxt_s      = srand_r;
      init_srand_nxt_s = 1'b1;
      gnt_nxt_s        = '0;
      rdata_nxt_s      = rdata_r;
      rvalid_nxt_s     = 1'b0;
      ready_nxt_s      = 1'b0;
      case (state_r)
         IDLE: begin
            if (start) begin
               state_nxt_s      = SEED;
               srand_nxt_s      = pick_seed(ent_cnt_r, FALLBACK_SEED);
               init_srand_nxt_s = 1'b0;
               phase_nxt_s      = 16'h0000;
            end else begin
               state_nxt_s = IDLE;
            end
         end
         SEED: begin
            if (phase_r == SEED_LAST) begin
               phase_nxt_s = 16'h0000;
               if (WARM_CYC == 0) begin
                  state_nxt_s = RUN;
                  ready_nxt_s = 1'b1;
               end else begin
                  state_nxt_s = WARM;
               end
            end else begin
               phase_nxt_s      = phase_r + 16'h0001;
               init_srand_nxt_s = 1'b0;
            end
         end
         WARM: begin
            if (phase_r == WARM_LAST) begin
               state_nxt_s = RUN;
               ready_nxt_s = 1'b1;
               phase_nxt_s = 16'h0000;
            end else begin
               phase_nxt_s = phase_r + 16'h0001;
            end
         end
         RUN: begin
            if (randi == 16'h0000) begin
               // Lock-up: suppress the grant and recover with the fallback seed.
               state_nxt_s      = SEED;
               srand_nxt_s      = FALLBACK_SEED;
               init_srand_nxt_s = 1'b0;
               phase_nxt_s      = 16'h0000;
            end else begin
               if (|arb_grant_s) begin
                  gnt_nxt_s    = arb_grant_s;
                  rvalid_nxt_s = 1'b1;
                  rdata_nxt_s  = randi;
                  if (arb_idx_s == PW'(NREQ - 1)) begin
                     ptr_nxt_s = '0;
                  end else begin
                     ptr_nxt_s = arb_idx_s + PW'(1);
                  end
               end else begin
                  ptr_nxt_s = ptr_r;
               end
               if (start) begin
                  state_nxt_s      = SEED;
                  srand_nxt_s      = pick_seed(ent_cnt_r, FALLBACK_SEED);
                  init_srand_nxt_s = 1'b0;
                  phase_nxt_s      = 16'h0000;
               end else begin
                  ready_nxt_s = 1'b1;
               end
            end
         end
         default: begin
            state_nxt_s = IDLE;
         end
      endcase
   end

   assign srand      = srand_r;
   assign init_srand = init_srand_r;
   assign gnt        = gnt_r;
   assign rdata      = rdata_r;
   assign rvalid     = rvalid_r;
   assign ready      = ready_r;

endmodule

// File: tb/tb_rand_sched.sv
// Directed bench for rand_sched with a behavioural 16-bit LFSR driving randi.
module tb_rand_sched;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic        force_zero = 1'b0;
   logic [3:0]  req = 4'b0000;
   logic [15:0] randi, srand, rdata;
   logic [15:0] lfsr, ent_model, prev, last, exp_seed;
   logic        init_srand, rvalid, ready;
   logic [3:0]  gnt, exp_g;
   int          checks = 0;
   int          failures = 0;

   rand_sched #(.NREQ(4), .SEED_CYC(2), .WARM_CYC(8), .FALLBACK_SEED(16'hACE1)) dut (
      .clk(clk), .rst(rst), .start(start), .randi(randi), .srand(srand),
      .init_srand(init_srand), .req(req), .gnt(gnt), .rdata(rdata),
      .rvalid(rvalid), .ready(ready)
   );

   always #5 clk = ~clk;

   assign randi = force_zero ? 16'h0000 : lfsr;

   always @(posedge clk or posedge rst) begin
      if (rst) lfsr <= 16'h0001;
      else if (!init_srand) lfsr <= srand;
      else lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
   end

   always @(posedge clk or posedge rst) begin
      if (rst) ent_model <= 16'h0000;
      else ent_model <= ent_model + 16'h0001;
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      repeat (2) tick;
      checks++;
      if ({srand, init_srand, gnt, rdata, rvalid, ready} !== {16'h0000, 1'b1, 4'b0000, 16'h0000, 1'b0, 1'b0}) begin
         failures++;
         $display("FAIL reset_outputs got=%h exp=%h", {srand, init_srand, gnt, rdata, rvalid, ready},
                  {16'h0000, 1'b1, 4'b0000, 16'h0000, 1'b0, 1'b0});
      end
      rst = 1'b0;
   endtask

   task automatic test_seed_and_rr;
      repeat (5) tick;
      start = 1'b1; req = 4'b1111;
      tick;
      start = 1'b0;
      checks++;
      if (srand !== 16'h0005 || init_srand !== 1'b0 || ready !== 1'b0) begin
         failures++; $display("FAIL seed5_load got srand=%h init=%b ready=%b exp 0005/0/0", srand, init_srand, ready);
      end
      tick;
      checks++;
      if (init_srand !== 1'b0 || srand !== 16'h0005) begin
         failures++; $display("FAIL seed5_hold got init=%b srand=%h exp 0/0005", init_srand, srand);
      end
      for (int i = 0; i < 8; i++) begin
         tick;
         checks++;
         if (init_srand !== 1'b1 || gnt !== 4'b0000 || ready !== 1'b0) begin
            failures++; $display("FAIL warm_%0d got init=%b gnt=%b ready=%b exp 1/0000/0", i, init_srand, gnt, ready);
         end
      end
      tick;
      checks++;
      if (ready !== 1'b1 || gnt !== 4'b0000) begin
         failures++; $display("FAIL ready_rise got ready=%b gnt=%b exp 1/0000", ready, gnt);
      end
      last = 16'h0000;
      for (int i = 0; i < 5; i++) begin
         prev = randi;
         tick;
         exp_g = 4'(4'b0001 << (i % 4));
         checks++;
         if (gnt !== exp_g || rvalid !== 1'b1 || rdata !== prev) begin
            failures++; $display("FAIL rr_%0d got gnt=%b rvalid=%b rdata=%h exp %b/1/%h", i, gnt, rvalid, rdata, exp_g, prev);
         end
         if (i > 0) begin
            checks++;
            if (rdata === last) begin
               failures++; $display("FAIL rr_distinct_%0d got rdata=%h exp differs from %h", i, rdata, last);
            end
         end
         last = rdata;
      end
      req = 4'b0000;
      tick;
      checks++;
      if (gnt !== 4'b0000 || rvalid !== 1'b0) begin
         failures++; $display("FAIL rr_idle got gnt=%b rvalid=%b exp 0000/0", gnt, rvalid);
      end
   endtask

   task automatic test_single_req;
      req = 4'b0100;
      prev = randi;
      tick;
      checks++;
      if (gnt !== 4'b0100 || rvalid !== 1'b1 || rdata !== prev) begin
         failures++; $display("FAIL single_gnt got gnt=%b rvalid=%b rdata=%h exp 0100/1/%h", gnt, rvalid, rdata, prev);
      end
      req = 4'b1111;
      tick;
      checks++;
      if (gnt !== 4'b1000) begin
         failures++; $display("FAIL ptr_after_single got gnt=%b exp 1000", gnt);
      end
      req = 4'b0000;
      tick;
      checks++;
      if (gnt !== 4'b0000 || rvalid !== 1'b0) begin
         failures++; $display("FAIL single_idle got gnt=%b rvalid=%b exp 0000/0", gnt, rvalid);
      end
   endtask

   task automatic test_lockup;
      req = 4'b0001; force_zero = 1'b1;
      tick;
      force_zero = 1'b0;
      checks++;
      if (gnt !== 4'b0000 || srand !== 16'hACE1 || init_srand !== 1'b0 || ready !== 1'b0) begin
         failures++; $display("FAIL lockup_enter got gnt=%b srand=%h init=%b ready=%b exp 0000/ace1/0/0", gnt, srand, init_srand, ready);
      end
      tick;
      checks++;
      if (init_srand !== 1'b0 || gnt !== 4'b0000) begin
         failures++; $display("FAIL lockup_seed2 got init=%b gnt=%b exp 0/0000", init_srand, gnt);
      end
      for (int i = 0; i < 8; i++) begin
         tick;
         checks++;
         if (init_srand !== 1'b1 || gnt !== 4'b0000 || ready !== 1'b0) begin
            failures++; $display("FAIL lockup_warm_%0d got init=%b gnt=%b ready=%b exp 1/0000/0", i, init_srand, gnt, ready);
         end
      end
      tick;
      checks++;
      if (ready !== 1'b1) begin
         failures++; $display("FAIL lockup_ready got ready=%b exp 1", ready);
      end
      prev = randi;
      tick;
      checks++;
      if (gnt !== 4'b0001 || rdata !== prev) begin
         failures++; $display("FAIL lockup_resume got gnt=%b rdata=%h exp 0001/%h", gnt, rdata, prev);
      end
      tick;
      checks++;
      if (gnt !== 4'b0000) begin
         failures++; $display("FAIL mask_no_double got gnt=%b exp 0000", gnt);
      end
      req = 4'b0000;
      tick;
   endtask

   task automatic test_restart_and_reset;
      exp_seed = (ent_model == 16'h0000) ? 16'hACE1 : ent_model;
      start = 1'b1;
      tick;
      start = 1'b0;
      checks++;
      if (srand !== exp_seed || init_srand !== 1'b0 || ready !== 1'b0) begin
         failures++; $display("FAIL restart_seed got srand=%h init=%b ready=%b exp %h/0/0", srand, init_srand, ready, exp_seed);
      end
      start = 1'b1;
      tick;
      start = 1'b0;
      checks++;
      if (srand !== exp_seed || init_srand !== 1'b0) begin
         failures++; $display("FAIL start_in_seed got srand=%h init=%b exp %h/0", srand, init_srand, exp_seed);
      end
      repeat (3) tick;
      rst = 1'b1;
      #1;
      checks++;
      if ({srand, init_srand, gnt, rdata, rvalid, ready} !== {16'h0000, 1'b1, 4'b0000, 16'h0000, 1'b0, 1'b0}) begin
         failures++;
         $display("FAIL async_reset got=%h exp=%h", {srand, init_srand, gnt, rdata, rvalid, ready},
                  {16'h0000, 1'b1, 4'b0000, 16'h0000, 1'b0, 1'b0});
      end
      tick;
      rst = 1'b0; start = 1'b1;
      tick;
      start = 1'b0;
      checks++;
      if (srand !== 16'hACE1 || init_srand !== 1'b0) begin
         failures++; $display("FAIL zero_entropy_seed got srand=%h init=%b exp ace1/0", srand, init_srand);
      end
      tick;
      req = 4'b1111;
      repeat (8) tick;
      checks++;
      if (ready !== 1'b0 || gnt !== 4'b0000 || init_srand !== 1'b1) begin
         failures++; $display("FAIL reseq_warm got ready=%b gnt=%b init=%b exp 0/0000/1", ready, gnt, init_srand);
      end
      tick;
      checks++;
      if (ready !== 1'b1) begin
         failures++; $display("FAIL reseq_ready got ready=%b exp 1", ready);
      end
      prev = randi;
      tick;
      checks++;
      if (gnt !== 4'b0001 || rdata !== prev) begin
         failures++; $display("FAIL reseq_first_gnt got gnt=%b rdata=%h exp 0001/%h", gnt, rdata, prev);
      end
      req = 4'b0000;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1);
   end

   initial begin
      test_reset;
      test_seed_and_rr;
      test_single_req;
      test_lockup;
      test_restart_and_reset;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
